// File: rtl/sap_alu_core.sv
// sap_alu_core: parametrised accumulator/ALU core.
//
// Holds accumulator A and operand register B. Operations are issued with a
// valid/ready handshake and always write their result back to A together
// with a registered C/Z/N/V flag set. Shifts by k run over k cycles, one bit
// per cycle, so the bus shows every intermediate value.
//
// Ports:
//   clk, reset       clock; synchronous active-low reset
//   din              load data for A (a_load) and B (b_load)
//   op_valid, op     operation request and opcode
//   shamt            shift amount for SHL/SHR
//   op_ready         high when an operation can be accepted (IDLE)
//   res_valid        one-cycle pulse when A and flags hold a new result
//   bus_oe, bus      bus = bus_oe ? A : 0 (combinational)
//   flag_c/z/n/v     registered carry, zero, negative, signed overflow
module sap_alu_core #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             a_load,
    input  logic             b_load,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   shamt,
    output logic             op_ready,
    output logic             res_valid,
    input  logic             bus_oe,
    output logic [WIDTH-1:0] bus,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_ADC = 3'b111;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [SHW-1:0]   cnt;      // shifts still to apply after the current one
    logic             dir_left;

    logic             op_fire;
    logic             is_shift;
    logic             shift_start;

    assign op_ready    = (state == IDLE);
    assign op_fire     = op_valid && op_ready;
    assign is_shift    = (op == OP_SHL) || (op == OP_SHR);
    assign shift_start = op_fire && is_shift && (shamt != '0);
    assign bus         = bus_oe ? a_q : '0;

    // ---------------- single-cycle ALU ----------------
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_v;

    always_comb begin
        b_eff = (op == OP_SUB) ? ~b_q : b_q;
        cin   = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? flag_c : 1'b0);
        sum   = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        alu_r = a_q;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADC: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                        (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_r = a_q & b_q;
            OP_OR:   alu_r = a_q | b_q;
            OP_XOR:  alu_r = a_q ^ b_q;
            default: alu_r = a_q;   // shift by 0: A unchanged, C=V=0
        endcase
    end

    // ---------------- one-bit shift step ----------------
    // The first step is taken on the accepting edge, so direction comes from
    // the opcode in IDLE and from the latched direction afterwards.
    logic             sh_left;
    logic [WIDTH-1:0] sh_val;
    logic             sh_out;

    always_comb begin
        sh_left = (state == IDLE) ? (op == OP_SHL) : dir_left;
        sh_val  = sh_left ? {a_q[WIDTH-2:0], 1'b0} : {1'b0, a_q[WIDTH-1:1]};
        sh_out  = sh_left ? a_q[WIDTH-1] : a_q[0];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (shift_start) state_nxt = SHIFT;
            SHIFT:   if (cnt == '0)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath / flags ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            dir_left  <= 1'b0;
            res_valid <= 1'b0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (b_load) b_q <= din;

            if (state == IDLE) begin
                if (shift_start) begin
                    a_q      <= sh_val;
                    flag_c   <= sh_out;
                    cnt      <= shamt - SHW'(1);
                    dir_left <= (op == OP_SHL);
                    if (shamt == SHW'(1)) begin
                        flag_z    <= (sh_val == '0);
                        flag_n    <= sh_val[WIDTH-1];
                        flag_v    <= 1'b0;
                        res_valid <= 1'b1;
                    end
                end else if (op_fire) begin
                    a_q       <= alu_r;
                    flag_c    <= alu_c;
                    flag_v    <= alu_v;
                    flag_z    <= (alu_r == '0);
                    flag_n    <= alu_r[WIDTH-1];
                    res_valid <= 1'b1;
                end else if (a_load) begin
                    a_q <= din;
                end
            end else if (cnt != '0) begin
                // SHIFT with steps left; the cycle with cnt==0 presents the
                // final result and then drops back to IDLE.
                a_q    <= sh_val;
                flag_c <= sh_out;
                cnt    <= cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    flag_z    <= (sh_val == '0);
                    flag_n    <= sh_val[WIDTH-1];
                    flag_v    <= 1'b0;
                    res_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sap_alu_core.sv
module tb_sap_alu_core;

    localparam int W  = 8;
    localparam int SW = $clog2(W);
    localparam int W2 = 16;
    localparam int SW2 = $clog2(W2);

    localparam int ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, SHL = 5, SHR = 6, ADC = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [W-1:0]  din;
    logic          a_load, b_load, op_valid, bus_oe;
    logic [2:0]    op;
    logic [SW-1:0] shamt;
    logic          op_ready, res_valid, flag_c, flag_z, flag_n, flag_v;
    logic [W-1:0]  bus;

    logic [W2-1:0]  din16, bus16;
    logic           a_load16, b_load16, op_valid16, bus_oe16;
    logic [2:0]     op16;
    logic [SW2-1:0] shamt16;
    logic           op_ready16, res_valid16, c16, z16, n16, v16;

    sap_alu_core #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .din(din), .a_load(a_load), .b_load(b_load),
        .op_valid(op_valid), .op(op), .shamt(shamt), .op_ready(op_ready),
        .res_valid(res_valid), .bus_oe(bus_oe), .bus(bus),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v));

    sap_alu_core #(.WIDTH(W2)) dut16 (
        .clk(clk), .reset(reset), .din(din16), .a_load(a_load16), .b_load(b_load16),
        .op_valid(op_valid16), .op(op16), .shamt(shamt16), .op_ready(op_ready16),
        .res_valid(res_valid16), .bus_oe(bus_oe16), .bus(bus16),
        .flag_c(c16), .flag_z(z16), .flag_n(n16), .flag_v(v16));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic done on plain integers.
    function automatic void ref_arith(input int w, input int o, input longint a, input longint b,
                                      input longint cin, output longint r, output bit c, output bit v);
        longint m, lim, sa, sb, s, ss, ci;
        m   = longint'(1) << w;
        lim = m / 2;
        sa  = (a >= lim) ? a - m : a;
        sb  = (b >= lim) ? b - m : b;
        ci  = (o == ADC) ? cin : 0;
        if (o == SUB) begin
            s = a - b; ss = sa - sb; c = (a >= b);
        end else begin
            s = a + b + ci; ss = sa + sb + ci; c = (s >= m);
        end
        r = ((s % m) + m) % m;
        v = (ss < -lim) || (ss >= lim);
    endfunction

    // 8-bit model state
    logic [W-1:0] ma, mb;
    bit mc, mz, mn, mv;

    task automatic tick();
        @(posedge clk);
        #1;
        op_valid = 1'b0; a_load = 1'b0; b_load = 1'b0;
    endtask

    task automatic check_all(input string tag, input bit rv, input bit rdy);
        chk({tag, ".bus"}, 32'(bus), bus_oe ? 32'(ma) : 32'd0);
        chk({tag, ".c"}, 32'(flag_c), 32'(mc));
        chk({tag, ".z"}, 32'(flag_z), 32'(mz));
        chk({tag, ".n"}, 32'(flag_n), 32'(mn));
        chk({tag, ".v"}, 32'(flag_v), 32'(mv));
        chk({tag, ".rv"}, 32'(res_valid), 32'(rv));
        chk({tag, ".rdy"}, 32'(op_ready), 32'(rdy));
    endtask

    task automatic model_op(input int o);
        longint r; bit c, v;
        case (o)
            ADD, SUB, ADC: begin
                ref_arith(W, o, longint'(ma), longint'(mb), longint'(mc), r, c, v);
                ma = r[W-1:0]; mc = c; mv = v;
            end
            AND_: begin ma = ma & mb; mc = 0; mv = 0; end
            OR_:  begin ma = ma | mb; mc = 0; mv = 0; end
            XOR_: begin ma = ma ^ mb; mc = 0; mv = 0; end
            default: begin mc = 0; mv = 0; end  // shift by 0
        endcase
        mz = (ma == 0);
        mn = ma[W-1];
    endtask

    // Cycles of a multi-cycle shift, with random ignored/dropped traffic.
    task automatic shift_seq(input int o, input int k, input logic [W-1:0] a0, input string tag);
        logic [W-1:0] t;
        bit bl;
        for (int j = 1; j <= k; j++) begin
            if (o == SHL) begin t = a0 << j; mc = a0[W-j]; end
            else          begin t = a0 >> j; mc = a0[j-1]; end
            ma = t;
            if (j == k) begin mz = (ma == 0); mn = ma[W-1]; mv = 0; end
            check_all($sformatf("%s.s%0d", tag, j), j == k, 0);
            op_valid = 1'($urandom_range(0, 1));
            op       = 3'($urandom);
            shamt    = SW'($urandom);
            a_load   = 1'($urandom_range(0, 1));
            bl       = 1'($urandom_range(0, 1));
            b_load   = bl;
            din      = W'($urandom);
            if (bl) mb = din;
            tick();
        end
        check_all({tag, ".done"}, 0, 1);
    endtask

    task automatic cyc(input bit v, input int o, input int s, input bit al, input bit bl,
                       input logic [W-1:0] d, input string tag);
        logic [W-1:0] a0;
        a0 = ma;
        op_valid = v; op = 3'(o); shamt = SW'(s);
        a_load = al; b_load = bl; din = d;
        tick();
        if (v && (o == SHL || o == SHR) && s != 0) begin
            if (bl) mb = d;
            shift_seq(o, s, a0, tag);
        end else begin
            if (v) model_op(o);
            else if (al) ma = d;
            if (bl) mb = d;
            check_all(tag, v, 1);
        end
    endtask

    task automatic ld_a(input logic [W-1:0] d); cyc(0, 0, 0, 1, 0, d, "ld_a"); endtask
    task automatic ld_b(input logic [W-1:0] d); cyc(0, 0, 0, 0, 1, d, "ld_b"); endtask

    // 16-bit ADD/SUB check
    task automatic chk16(input int o, input logic [W2-1:0] a, input logic [W2-1:0] b);
        longint r; bit c, v;
        din16 = a; a_load16 = 1; @(posedge clk); #1; a_load16 = 0;
        din16 = b; b_load16 = 1; @(posedge clk); #1; b_load16 = 0;
        op16 = 3'(o); op_valid16 = 1; @(posedge clk); #1; op_valid16 = 0;
        ref_arith(W2, o, longint'(a), longint'(b), 0, r, c, v);
        chk("w16.bus", 32'(bus16), 32'(r[W2-1:0]));
        chk("w16.c", 32'(c16), 32'(c));
        chk("w16.z", 32'(z16), 32'(r == 0));
        chk("w16.n", 32'(n16), 32'(r[W2-1]));
        chk("w16.v", 32'(v16), 32'(v));
        chk("w16.rv", 32'(res_valid16), 32'd1);
    endtask

    initial begin
        reset = 0; din = 0; a_load = 0; b_load = 0; op_valid = 0; op = 0; shamt = 0; bus_oe = 1;
        din16 = 0; a_load16 = 0; b_load16 = 0; op_valid16 = 0; op16 = 0; shamt16 = 0; bus_oe16 = 1;
        ma = 0; mb = 0; mc = 0; mz = 0; mn = 0; mv = 0;
        tick(); tick();
        check_all("reset", 0, 1);
        chk("w16.reset", 32'(bus16), 32'd0);
        reset = 1;

        // Basic ADD and bus enable
        ld_a(8'h05); ld_b(8'h03);
        cyc(1, ADD, 0, 0, 0, 0, "add");
        chk("tp.add", 32'(bus), 32'h08);
        bus_oe = 0; #1;
        chk("bus_off", 32'(bus), 32'h00);
        bus_oe = 1;

        // Carry, ADC, overflow
        ld_a(8'hFF); ld_b(8'h01); cyc(1, ADD, 0, 0, 0, 0, "add_c");
        ld_b(8'h00); cyc(1, ADC, 0, 0, 0, 0, "adc");
        chk("tp.adc", 32'(bus), 32'h01);
        ld_a(8'h7F); ld_b(8'h01); cyc(1, ADD, 0, 0, 0, 0, "add_v");

        // SUB borrow / equal
        ld_a(8'h03); ld_b(8'h05); cyc(1, SUB, 0, 0, 0, 0, "sub_b");
        chk("tp.sub", 32'(bus), 32'hFE);
        ld_a(8'h05); ld_b(8'h05); cyc(1, SUB, 0, 0, 0, 0, "sub_z");

        // Logic ops back to back
        ld_a(8'hC3); ld_b(8'h5A);
        cyc(1, AND_, 0, 0, 0, 0, "and");
        cyc(1, OR_, 0, 0, 0, 0, "or");
        cyc(1, XOR_, 0, 0, 0, 0, "xor");

        // Multi-cycle shifts
        ld_a(8'h81); cyc(1, SHL, 3, 0, 0, 0, "shl3");
        chk("tp.shl", 32'(bus), 32'h08);
        ld_a(8'h81); cyc(1, SHR, 1, 0, 0, 0, "shr1");
        chk("tp.shr", 32'(bus), 32'h40);
        chk("tp.shr.c", 32'(flag_c), 32'd1);
        ld_a(8'hA5); cyc(1, SHR, 7, 0, 0, 0, "shr7");

        // Same-cycle events in IDLE
        ld_a(8'h10); ld_b(8'h01);
        cyc(1, ADD, 0, 1, 0, 8'h55, "add_ald");
        cyc(1, ADD, 0, 0, 1, 8'h22, "add_bld");
        cyc(1, ADD, 0, 0, 0, 0, "add_newb");
        cyc(1, SHL, 0, 0, 0, 0, "shl0");

        // Reset in the middle of a shift
        ld_a(8'h81); ld_b(8'h3C);
        op_valid = 1; op = 3'(SHL); shamt = SW'(5);
        tick(); tick();
        reset = 0; tick(); reset = 1;
        ma = 0; mb = 0; mc = 0; mz = 0; mn = 0; mv = 0;
        check_all("rst_mid", 0, 1);
        tick();
        check_all("rst_mid2", 0, 1);
        cyc(1, ADD, 0, 0, 0, 0, "rst_b0");

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 9);
            bus_oe = ($urandom_range(0, 7) != 0);
            if (r == 0)      ld_a(W'($urandom));
            else if (r == 1) ld_b(W'($urandom));
            else cyc(1, $urandom_range(0, 7), $urandom_range(0, W-1),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     W'($urandom), $sformatf("rnd%0d", i));
        end
        bus_oe = 1;

        // 16-bit datapath
        chk16(ADD, 16'hFFFF, 16'h0001);
        chk16(ADD, 16'h7FFF, 16'h0001);
        chk16(SUB, 16'h0003, 16'h0005);
        chk16(SUB, 16'h0005, 16'h0005);
        chk16(SUB, 16'h8000, 16'h0001);
        for (int i = 0; i < 30; i++)
            chk16(($urandom_range(0, 1) != 0) ? SUB : ADD, W2'($urandom), W2'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sap_alu_core.md
# sap_alu_core

Parametrised accumulator/ALU core: the successor to the fixed 8-bit A/B-register-plus-adder datapath. It holds an accumulator A and an operand register B, executes a valid/ready-issued operation set (add, subtract, add-with-carry, logic, multi-cycle shifts), and writes results back to A. It also keeps a registered flag set and drives A onto the bus under an output enable. It sits between the bus and the future control sequencer.

## Interface
- `WIDTH`, 8: data width of A, B, din and bus (≥ 2).
- `SHW`, $clog2(WIDTH): width of the shift-amount field.
- `clk` in 1: single system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low reset (sampled on the rising edge of `clk`; low = reset).
- `din` in WIDTH: load data for A/B.
- `a_load` in 1: load `din` into A.
- `b_load` in 1: load `din` into B.
- `op_valid` in 1: operation request.
- `op` in 3: opcode (see Operation).
- `shamt` in SHW: shift amount for SHL/SHR.
- `op_ready` out 1: core can accept an operation this cycle.
- `res_valid` out 1: one-cycle pulse; A and flags hold a new result.
- `bus_oe` in 1: drive A onto `bus`.
- `bus` out WIDTH: `bus_oe ? A : 0`, combinational.
- `flag_c`, `flag_z`, `flag_n`, `flag_v` out 1 each: registered carry, zero, negative and signed overflow.

## Operation
- Opcodes:
  - 000 ADD: A ← A+B.
  - 001 SUB: A ← A+~B+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: logical shift left of A by `shamt`.
  - 110 SHR: logical shift right of A by `shamt`.
  - 111 ADC: A ← A+B+flag_c.
- Arithmetic is computed WIDTH+1 bits wide and the result is truncated to WIDTH.
  - C = bit WIDTH of the sum. For SUB, C=1 means no borrow (A ≥ B unsigned).
  - V = (A[msb]==B'[msb]) && (R[msb]!=A[msb]), where B' is B for ADD/ADC and ~B for SUB.
- Logic ops clear C and V.
- Shifts: C = last bit shifted out; V = 0. With `shamt`=0, C=0.
- Every op updates Z (R==0) and N (R[msb]).
- FSM states IDLE, SHIFT.
  - IDLE: `op_ready`=1. A handshake (`op_valid`&&`op_ready`) with a non-shift op, or with a shift op and `shamt`=0, writes A and flags at that edge. The FSM stays in IDLE.
  - IDLE, shift op with `shamt`≥1: latch direction and count=`shamt`, go to SHIFT.
  - SHIFT: A shifts 1 bit per cycle; C tracks the bit shifted out. Count decrements each cycle. On the cycle count reaches 1, the final shift is applied, Z/N/V are updated, and the FSM returns to IDLE.
  - SHIFT: `op_ready`=0; `op_valid` is ignored (no queueing).
- Load rules:
  - `b_load` is honoured in any state. An op issued in the same cycle uses the old B.
  - `a_load` is honoured only in IDLE with no accepted op. An accepted op has priority and the load is dropped. `a_load` in SHIFT is dropped.
  - Loads do not change flags or `res_valid`.
- `bus` reflects A combinationally, including intermediate shift values.

## Timing
- Reset (`reset`=0 at a rising edge) takes priority over everything:
  - A, B, all flags, count and `res_valid` ← 0.
  - FSM ← IDLE.
  - `op_ready`=1 from the first cycle after reset.
  - Reset mid-SHIFT aborts the shift; no `res_valid` is issued.
- Single-cycle ops: accepted at edge N; A and flags are valid and `res_valid`=1 in cycle N+1. Back-to-back issue every cycle is allowed and uses the updated A/flags.
- Shift by k (1 ≤ k ≤ WIDTH-1): accepted at edge N. `op_ready`=0 for cycles N+1..N+k. Final A and `res_valid`=1 in cycle N+k. `op_ready`=1 again in N+k+1.
- `shamt` ≥ WIDTH is impossible for power-of-two WIDTH. For other widths it shifts `shamt` cycles: result 0, C = last bit out.
- `res_valid` is low on every cycle without a completing op.

## Test plan
- Reset, then load A=0x05 and B=0x03; ADD → A=0x08, C=0 Z=0 N=0 V=0, `res_valid` one cycle later; `bus_oe`=1 → bus=0x08, `bus_oe`=0 → bus=0x00.
- A=0xFF, B=0x01, ADD → A=0x00, C=1, Z=1. Then B=0x00, ADC → A=0x01, C=0. Then A=0x7F, B=0x01, ADD → A=0x80, V=1, N=1.
- A=0x03, B=0x05, SUB → A=0xFE, C=0 (borrow), N=1. Then A=0x05, B=0x05, SUB → 0x00, C=1, Z=1.
- A=0x81, SHL `shamt`=3 → `op_ready` low 3 cycles, op_valid pulses during SHIFT ignored, final A=0x08, C=0 (last bit out A[5] of original = 0), `res_valid` at cycle N+3. Then SHR 1 of 0x81 → 0x40, C=1.
- Same-cycle events in IDLE: `a_load`+ADD → load dropped, ADD result kept. `b_load`+ADD → old B used, new B stored. SHL `shamt`=0 → single cycle, A unchanged, C=0.
- Assert `reset`=0 mid-SHIFT → next cycle A=B=flags=0, `op_ready`=1, no `res_valid`. Repeat ADD/SUB checks with WIDTH=16.
